// File: rtl/othello_move_ctrl.sv
// -----------------------------------------------------------------------------
// othello_move_ctrl
// Turn controller for the Othello board store. Holds the cursor and the side
// to move, turns a placement key into a detect pass followed by a conditional
// write pass, and hands the turn over when a move or pass completes.
//
// Ports
//   clock        system clock
//   resetn       synchronous reset, active high
//   key_up/down/left/right  single-cycle cursor move pulses
//   key_place    play at the cursor
//   key_pass     pass the turn
//   q[1:0]       board cell at (x,y); q[1] set = occupied
//   dir[7:0]     legal capture-direction mask from the board
//   x, y         cursor column/row (board address)
//   side         side to move
//   detecten     detect request level
//   writeen      write request level
//   busy         high outside IDLE
//   invalid      one-cycle pulse on a rejected placement
//   turn_done    one-cycle pulse when a move or pass completes
//   pass_count   consecutive passes, saturating at 2 (2 = game over)
//
// state  | meaning
// IDLE   | cursor movable, waiting for place/pass
// CHECK  | occupancy known; reject or start detect
// DETECT | detecten high DET_CYCLES cycles, then SETTLE quiet cycles
// EVAL   | act on the sampled dir mask
// WRITE  | writeen high WR_CYCLES cycles
// DONE   | hand over the turn, update pass_count
// -----------------------------------------------------------------------------
module othello_move_ctrl #(
  parameter int DET_CYCLES = 8,
  parameter int WR_CYCLES  = 8,
  parameter int SETTLE     = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_place,
  input  logic       key_pass,
  input  logic [1:0] q,
  input  logic [7:0] dir,
  output logic [2:0] x,
  output logic [2:0] y,
  output logic       side,
  output logic       detecten,
  output logic       writeen,
  output logic       busy,
  output logic       invalid,
  output logic       turn_done,
  output logic [1:0] pass_count
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CHECK  = 3'd1;
  localparam logic [2:0] DETECT = 3'd2;
  localparam logic [2:0] EVAL   = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  localparam int CW = 8;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    x_q, x_d, y_q, y_d;
  logic          side_q, side_d;
  logic [1:0]    pass_count_q, pass_count_d;
  logic          occ_q, occ_d;
  logic          dir_nz_q, dir_nz_d;
  logic          pass_flag_q, pass_flag_d;
  logic          detecten_q, detecten_d;
  logic          writeen_q, writeen_d;
  logic          busy_q, busy_d;
  logic          invalid_q, invalid_d;
  logic          turn_done_q, turn_done_d;
  logic          keys_en;

  // Only q[1] carries occupancy; q[0] distinguishes nothing we need.
  logic unused_q0;
  assign unused_q0 = q[0];

  assign keys_en = (pass_count_q != 2'd2);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    x_d          = x_q;
    y_d          = y_q;
    side_d       = side_q;
    pass_count_d = pass_count_q;
    occ_d        = occ_q;
    dir_nz_d     = dir_nz_q;
    pass_flag_d  = pass_flag_q;
    invalid_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (keys_en) begin
          if (key_place) begin
            // Occupancy is sampled here so the reject pulse lands in the
            // CHECK cycle itself.
            state_d   = CHECK;
            occ_d     = q[1];
            invalid_d = q[1];
          end else if (key_pass) begin
            state_d     = DONE;
            pass_flag_d = 1'b1;
          end else begin
            // Moves are suppressed in the accept cycle so the address that
            // was checked is the one detected and written.
            x_d = x_q + {2'b00, key_right} - {2'b00, key_left};
            y_d = y_q + {2'b00, key_down}  - {2'b00, key_up};
          end
        end
      end
      CHECK: begin
        if (occ_q) begin
          state_d = IDLE;
        end else begin
          state_d = DETECT;
          cnt_d   = CW'(DET_CYCLES + SETTLE - 1);
        end
      end
      DETECT: begin
        if (cnt_q == '0) begin
          // Last settle cycle: dir is stable, latch it once.
          state_d   = EVAL;
          dir_nz_d  = |dir;
          invalid_d = ~|dir;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      EVAL: begin
        if (dir_nz_q) begin
          state_d = WRITE;
          cnt_d   = CW'(WR_CYCLES - 1);
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE: begin
        state_d     = IDLE;
        side_d      = ~side_q;
        pass_flag_d = 1'b0;
        if (pass_flag_q)
          pass_count_d = (pass_count_q == 2'd2) ? 2'd2 : pass_count_q + 2'd1;
        else
          pass_count_d = 2'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state
  // they belong to while still coming straight from flops.
  always_comb begin
    detecten_d  = (state_d == DETECT) && (cnt_d >= CW'(SETTLE));
    writeen_d   = (state_d == WRITE);
    busy_d      = (state_d != IDLE);
    turn_done_d = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      x_q          <= 3'd3;
      y_q          <= 3'd3;
      side_q       <= 1'b0;
      pass_count_q <= 2'd0;
      occ_q        <= 1'b0;
      dir_nz_q     <= 1'b0;
      pass_flag_q  <= 1'b0;
      detecten_q   <= 1'b0;
      writeen_q    <= 1'b0;
      busy_q       <= 1'b0;
      invalid_q    <= 1'b0;
      turn_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      side_q       <= side_d;
      pass_count_q <= pass_count_d;
      occ_q        <= occ_d;
      dir_nz_q     <= dir_nz_d;
      pass_flag_q  <= pass_flag_d;
      detecten_q   <= detecten_d;
      writeen_q    <= writeen_d;
      busy_q       <= busy_d;
      invalid_q    <= invalid_d;
      turn_done_q  <= turn_done_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign side       = side_q;
  assign pass_count = pass_count_q;
  assign detecten   = detecten_q;
  assign writeen    = writeen_q;
  assign busy       = busy_q;
  assign invalid    = invalid_q;
  assign turn_done  = turn_done_q;

endmodule
